// File: rtl/mux16_rr_sched.sv
// Round-robin owner of the shared 16:1 mux select, with a dead cycle between grants.
// Optional MUX16_HOLD_LIMIT_EN caps a grant at MAX_HOLD cycles and pulses preempt.
module mux16_rr_sched #(
  parameter int MAX_HOLD = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  sel,
  output logic        sel_valid,
  output logic [15:0] gnt,
  output logic        preempt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [3:0]  sel_d;
  logic        valid_d;
  logic [15:0] gnt_d;
  logic [3:0]  ptr, ptr_d;
  logic [3:0]  pick, idx;
  logic        found;
  logic        rel, frc;

`ifdef MUX16_HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic              pre_q, pre_d;
  assign preempt = pre_q;
`else
  assign preempt = 1'b0;
`endif

  // first requester at or after ptr, wrapping 15 -> 0
  always_comb begin
    pick  = ptr;
    idx   = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = ptr + 4'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    sel_d   = sel;
    valid_d = sel_valid;
    gnt_d   = gnt;
    ptr_d   = ptr;
    rel     = 1'b0;
    frc     = 1'b0;
`ifdef MUX16_HOLD_LIMIT_EN
    hold_d  = hold_cnt;
    pre_d   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          sel_d   = pick;
          valid_d = 1'b1;
          gnt_d   = 16'(1) << pick;
`ifdef MUX16_HOLD_LIMIT_EN
          hold_d  = '0;
`endif
        end
      end
      BUSY: begin
        rel = done | ~req[sel];
`ifdef MUX16_HOLD_LIMIT_EN
        hold_d = hold_cnt + 1'b1;
        frc    = !rel &&
                 (hold_cnt == HOLD_W'(MAX_HOLD - 1));
        pre_d  = frc;
`endif
        if (rel || frc) begin
          state_d = GAP;
          valid_d = 1'b0;
          gnt_d   = '0;
          ptr_d   = sel + 4'd1;
        end
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      sel_valid <= 1'b0;
      gnt       <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_d;
      sel       <= sel_d;
      sel_valid <= valid_d;
      gnt       <= gnt_d;
      ptr       <= ptr_d;
    end
  end

`ifdef MUX16_HOLD_LIMIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      pre_q    <= 1'b0;
    end else begin
      hold_cnt <= hold_d;
      pre_q    <= pre_d;
    end
  end
`endif

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Scoreboard bench for mux16_rr_sched: driver pushes expected post-edge
// outputs from an abstract owner/queue model, a negedge monitor compares.
module tb_mux16_rr_sched;

  localparam int MH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic        done = 1'b0;
  logic [3:0]  sel;
  logic        sel_valid;
  logic [15:0] gnt;
  logic        preempt;

  mux16_rr_sched #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel), .sel_valid(sel_valid), .gnt(gnt),
    .preempt(preempt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  sel;
    logic        v;
    logic [15:0] g;
    logic        p;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;

  // abstract model: who owns the mux, dead cycles left, next priority
  int         owner = -1;
  int         gap = 0;
  int         nxt = 0;
  int         held = 0;
  int         m_sel = 0;
  bit         m_pre = 0;
`ifdef MUX16_HOLD_LIMIT_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  task automatic model(input logic [15:0] r, input logic d,
                       input logic rs);
    bit normal;
    m_pre = 0;
    if (rs) begin
      owner = -1; gap = 0; nxt = 0; held = 0; m_sel = 0;
    end else if (owner >= 0) begin
      held++;
      normal = d || !r[owner];
      if (normal || (HOLD_ON && held == MH)) begin
        m_pre = !normal;
        nxt   = (owner + 1) % 16;
        owner = -1;
        gap   = 1;
      end
    end else if (gap > 0) begin
      gap--;
    end else if (r != 0) begin
      for (int j = 0; j < 16; j++) begin
        if (owner < 0 && r[(nxt + j) % 16]) owner = (nxt + j) % 16;
      end
      m_sel = owner;
      held  = 0;
    end
  endtask

  task automatic step(input logic [15:0] r, input logic d,
                      input logic rs);
    exp_t e;
    @(negedge clk);
    #1;
    req = r; done = d; rst = rs;
    model(r, d, rs);
    e.sel = 4'(m_sel);
    e.v   = (owner >= 0);
    e.g   = (owner >= 0) ? (16'(1) << owner) : 16'h0;
    e.p   = m_pre;
    expq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      total++;
      if (sel === e.sel && sel_valid === e.v &&
          gnt === e.g && preempt === e.p)
        passed++;
      else
        $display("FAIL outputs cyc=%0d got sel=%0d v=%b gnt=%h pre=%b want sel=%0d v=%b gnt=%h pre=%b",
                 cyc, sel, sel_valid, gnt, preempt,
                 e.sel, e.v, e.g, e.p);
    end
  end

  initial begin
    logic [15:0] r;
    r = '0;
    // reset then idle
    repeat (2) step(16'h0, 1'b0, 1'b1);
    repeat (10) step(16'h0, 1'b0, 1'b0);
    // single request, done four cycles after grant
    repeat (4) step(16'h0020, 1'b0, 1'b0);
    step(16'h0020, 1'b1, 1'b0);
    repeat (4) step(16'h0, 1'b0, 1'b0);
    // full round-robin sweep with done held high
    repeat (55) step(16'hFFFF, 1'b1, 1'b0);
    repeat (3) step(16'h0, 1'b0, 1'b0);
    // wrap: grant 13, then 0 and 3 requested
    repeat (2) step(16'h2000, 1'b0, 1'b0);
    repeat (3) step(16'h0, 1'b0, 1'b0);
    repeat (10) step(16'h0009, 1'b1, 1'b0);
    repeat (3) step(16'h0, 1'b0, 1'b0);
    // withdrawal, regrant, reset mid-transfer
    repeat (3) step(16'h0080, 1'b0, 1'b0);
    step(16'h0, 1'b0, 1'b0);
    repeat (3) step(16'h0080, 1'b0, 1'b0);
    step(16'h0080, 1'b0, 1'b1);
    repeat (4) step(16'h0081, 1'b0, 1'b0);
    step(16'h0, 1'b0, 1'b1);
    // long hold without done, then done right at the limit
    repeat (25) step(16'h0003, 1'b0, 1'b0);
    step(16'h0, 1'b0, 1'b1);
    step(16'h0001, 1'b0, 1'b0);
    repeat (MH - 1) step(16'h0001, 1'b0, 1'b0);
    step(16'h0001, 1'b1, 1'b0);
    repeat (4) step(16'h0, 1'b0, 1'b0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: r = 16'h0;
          1: r = 16'(1) << $urandom_range(0, 15);
          2: r = 16'($urandom);
          default: r = 16'($urandom) & 16'($urandom);
        endcase
      end
      step(r, ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 99) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    #2;
    total++;
    if (expq.size() == 0) passed++;
    else $display("FAIL drain left=%0d want 0", expq.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
